// File: rtl/branch_resolve_unit.sv
// Resolves conditional branches (direction, next PC, mispredict), trains a 2-bit BHT and counts mispredicts.
// Latency 1: result registered on acceptance; in_ready drops only while a held result waits on out_ready.
module branch_resolve_unit #(
    parameter int XLEN      = 64,
    parameter int BHT_DEPTH = 16,
    parameter int CNT_W     = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic            pred_taken,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_taken,
    output logic [XLEN-1:0] out_target,
    output logic            out_mispredict,
    output logic            out_illegal,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            lookup_taken,
    output logic [CNT_W-1:0] mispredict_count
);
    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic              out_valid_q, out_taken_q, out_mispredict_q, out_illegal_q;
    logic [XLEN-1:0]   out_target_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        bht_q [BHT_DEPTH];
    logic [1:0]        bht_cur, bht_d;
    logic [IDX_W-1:0]  upd_idx, look_idx;
    logic              accept, taken_c, legal_c, mis_c;
    logic [XLEN-1:0]   target_c;
    logic              unused_lookup_bits;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        taken_c = 1'b0;
        legal_c = 1'b1;
        case (funct3)
            3'b000:  taken_c = (rs1_data == rs2_data);
            3'b001:  taken_c = (rs1_data != rs2_data);
            3'b100:  taken_c = ($signed(rs1_data) <  $signed(rs2_data));
            3'b101:  taken_c = ($signed(rs1_data) >= $signed(rs2_data));
            3'b110:  taken_c = (rs1_data <  rs2_data);
            3'b111:  taken_c = (rs1_data >= rs2_data);
            default: legal_c = 1'b0;
        endcase
    end

    assign mis_c    = legal_c && (taken_c ^ pred_taken);
    assign target_c = taken_c ? (pc + imm) : (pc + XLEN'(4));

    assign upd_idx  = pc[IDX_W+1:2];
    assign look_idx = lookup_pc[IDX_W+1:2];
    assign bht_cur  = bht_q[upd_idx];
    // Reads the registered array, so a same-cycle update is not visible yet.
    assign lookup_taken = bht_q[look_idx][1];
    assign unused_lookup_bits = ^{lookup_pc[XLEN-1:IDX_W+2], lookup_pc[1:0]};

    always_comb begin
        bht_d = bht_cur;
        if (taken_c) begin
            if (bht_cur != 2'b11) bht_d = bht_cur + 2'd1;
        end else if (bht_cur != 2'b00) begin
            bht_d = bht_cur - 2'd1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (accept && mis_c && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= 2'b01;
            cnt_q <= '0;
        end else begin
            if (accept && legal_c) bht_q[upd_idx] <= bht_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q      <= 1'b0;
            out_taken_q      <= 1'b0;
            out_mispredict_q <= 1'b0;
            out_illegal_q    <= 1'b0;
            out_target_q     <= '0;
        end else if (accept) begin
            out_valid_q      <= 1'b1;
            out_taken_q      <= taken_c && legal_c;
            out_mispredict_q <= mis_c;
            out_illegal_q    <= !legal_c;
            out_target_q     <= target_c;
        end else if (out_ready) begin
            out_valid_q      <= 1'b0;
        end
    end

    assign out_valid        = out_valid_q;
    assign out_taken        = out_taken_q;
    assign out_mispredict   = out_mispredict_q;
    assign out_illegal      = out_illegal_q;
    assign out_target       = out_target_q;
    assign mispredict_count = cnt_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed + random bench for branch_resolve_unit with a result scoreboard and a BHT/counter model.
module tb_branch_resolve_unit;
    localparam int XLEN = 64;
    localparam int BHT  = 16;
    localparam int CW   = 4;

    logic            clk = 1'b0;
    logic            reset, in_valid, in_ready, pred_taken;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_data, rs2_data, pc, imm, lookup_pc, out_target;
    logic            out_valid, out_ready, out_taken, out_mispredict, out_illegal, lookup_taken;
    logic [CW-1:0]   mispredict_count;

    branch_resolve_unit #(.XLEN(XLEN), .BHT_DEPTH(BHT), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .rs1_data(rs1_data), .rs2_data(rs2_data), .pc(pc), .imm(imm),
        .pred_taken(pred_taken), .out_valid(out_valid), .out_ready(out_ready),
        .out_taken(out_taken), .out_target(out_target), .out_mispredict(out_mispredict),
        .out_illegal(out_illegal), .lookup_pc(lookup_pc), .lookup_taken(lookup_taken),
        .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            taken;
        logic [XLEN-1:0] target;
        logic            mis;
        logic            ill;
        logic [CW-1:0]   cnt;
    } exp_t;

    exp_t          sb[$];
    logic [1:0]    mdl_bht [BHT];
    logic [CW-1:0] mdl_cnt;
    int            n_vec = 0;
    int            n_err = 0;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < BHT; i++) mdl_bht[i] = 2'b01;
        mdl_cnt = '0;
    endtask

    task automatic set_in(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [XLEN-1:0] p, input logic [XLEN-1:0] im, input logic pr);
        funct3 = f3; rs1_data = a; rs2_data = b; pc = p; imm = im; pred_taken = pr;
        lookup_pc = p;
    endtask

    // Predict the result of the request currently on the inputs and advance the models.
    task automatic predict();
        exp_t       e;
        logic       t, ill;
        logic [3:0] idx;
        ill = (funct3 == 3'b010) || (funct3 == 3'b011);
        case (funct3)
            3'b000:  t = (rs1_data == rs2_data);
            3'b001:  t = (rs1_data != rs2_data);
            3'b100:  t = ($signed(rs1_data) < $signed(rs2_data));
            3'b101:  t = !($signed(rs1_data) < $signed(rs2_data));
            3'b110:  t = (rs1_data < rs2_data);
            3'b111:  t = !(rs1_data < rs2_data);
            default: t = 1'b0;
        endcase
        idx = pc[5:2];
        if (!ill) begin
            if (t && mdl_bht[idx] != 2'b11) mdl_bht[idx] = mdl_bht[idx] + 2'd1;
            else if (!t && mdl_bht[idx] != 2'b00) mdl_bht[idx] = mdl_bht[idx] - 2'd1;
            if ((t != pred_taken) && mdl_cnt != 4'hF) mdl_cnt = mdl_cnt + 4'd1;
        end
        e.taken  = t;
        e.target = t ? pc + imm : pc + 64'd4;
        e.mis    = ill ? 1'b0 : (t != pred_taken);
        e.ill    = ill;
        e.cnt    = mdl_cnt;
        sb.push_back(e);
    endtask

    // Called at posedge+1; returns at the next posedge+1 with the request accepted.
    task automatic req(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] p, input logic [XLEN-1:0] im, input logic pr);
        set_in(f3, a, b, p, im, pr);
        in_valid = 1'b1;
        #1;
        chk("in_ready", in_ready, 1'b1);
        chk("lookup_pre_update", lookup_taken, mdl_bht[p[5:2]][1]);
        predict();
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic look_all();
        for (int i = 0; i < BHT; i++) begin
            lookup_pc = {$urandom, $urandom};
            lookup_pc[5:2] = i[3:0];
            #1;
            chk("lookup", lookup_taken, mdl_bht[i][1]);
        end
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", out_valid, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_taken", out_taken, e.taken);
                chk("out_target", out_target, e.target);
                chk("out_mispredict", out_mispredict, e.mis);
                chk("out_illegal", out_illegal, e.ill);
                chk("mispredict_count", mispredict_count, e.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        set_in(3'b000, '0, '0, '0, '0, 1'b0);
        model_reset();
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_target", out_target, '0);
        chk("rst_count", mispredict_count, '0);
        chk("rst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        reset = 1'b0;
        idle(1);

        // Signed vs unsigned less-than on the same operands, then an illegal funct3.
        req(3'b100, '1, 64'd1, 64'h1000, 64'h20, 1'b0);
        req(3'b110, '1, 64'd1, 64'h1000, 64'h20, 1'b0);
        req(3'b011, 64'd7, 64'd7, 64'h1000, 64'h20, 1'b1);
        req(3'b000, 64'd9, 64'd9, 64'h2008, 64'hFFFF_FFFF_FFFF_FFF0, 1'b1);
        req(3'b001, 64'd9, 64'd9, 64'h200C, 64'h40, 1'b1);
        req(3'b101, 64'h8000_0000_0000_0000, 64'd0, 64'h2010, 64'h40, 1'b1);
        req(3'b111, 64'd5, 64'd5, 64'h2014, 64'h40, 1'b0);
        req(3'b010, 64'd1, 64'd2, 64'h2018, 64'h40, 1'b0);
        idle(2);
        look_all();

        // Train one entry up to saturation and back down to zero.
        repeat (3) req(3'b000, 64'd5, 64'd5, 64'h40, 64'h8, 1'b1);
        idle(2);
        look_all();
        repeat (4) req(3'b000, 64'd5, 64'd6, 64'h40, 64'h8, 1'b0);
        idle(2);
        look_all();
        req(3'b000, 64'd5, 64'd5, 64'h40, 64'h8, 1'b1);
        idle(2);
        look_all();

        for (int k = 0; k < 40; k++) begin
            logic [2:0]      f;
            logic [XLEN-1:0] a, b;
            f = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom};
            b = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom};
            req(f, a, b, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
        end
        idle(2);
        look_all();

        // Enough guaranteed mispredicts to saturate the 4-bit counter.
        repeat (17) req(3'b000, 64'd1, 64'd1, 64'h80, 64'h4, 1'b0);
        idle(2);

        // Backpressure: B waits while A is held, then is accepted as A is consumed.
        out_ready = 1'b0;
        req(3'b001, 64'd1, 64'd2, 64'h3000, 64'h100, 1'b0);
        set_in(3'b000, 64'd3, 64'd3, 64'h3004, 64'h200, 1'b1);
        in_valid = 1'b1;
        repeat (3) begin
            #1;
            chk("stall_in_ready", in_ready, 1'b0);
            chk("stall_out_valid", out_valid, 1'b1);
            chk("stall_out_target", out_target, sb[0].target);
            chk("stall_out_taken", out_taken, sb[0].taken);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        chk("unstall_in_ready", in_ready, 1'b1);
        predict();
        @(posedge clk); #1;
        in_valid = 1'b0;
        idle(2);

        // Fall-through target wraps past the top of the address space.
        req(3'b001, 64'd4, 64'd4, 64'hFFFF_FFFF_FFFF_FFFC, 64'h10, 1'b0);
        idle(2);

        // Reset while a result is stalled discards it and restores weakly-not-taken history.
        out_ready = 1'b0;
        req(3'b000, 64'd2, 64'd2, 64'h44, 64'h10, 1'b0);
        idle(1);
        chk("prereset_out_valid", out_valid, 1'b1);
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_out_taken", out_taken, 1'b0);
        chk("midrst_out_mispredict", out_mispredict, 1'b0);
        chk("midrst_out_illegal", out_illegal, 1'b0);
        chk("midrst_out_target", out_target, '0);
        chk("midrst_count", mispredict_count, '0);
        chk("midrst_in_ready", in_ready, 1'b1);
        sb.delete();
        model_reset();
        look_all();
        set_in(3'b000, 64'd1, 64'd1, 64'h48, 64'h10, 1'b0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        chk("rst_no_accept", out_valid, 1'b0);
        in_valid = 1'b0;
        reset = 1'b0;
        idle(1);
        chk("post_rst_out_valid", out_valid, 1'b0);
        out_ready = 1'b1;
        req(3'b000, 64'd2, 64'd2, 64'h40, 64'h10, 1'b1);
        idle(2);
        look_all();

        idle(2);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter XLEN, default 64, giving the operand, PC and immediate width.
REQ-002 SHALL have parameter BHT_DEPTH, default 16, giving the number of branch-history entries; it is a power of 2 and at least 2.
REQ-003 SHALL have parameter CNT_W, default 32, giving the mispredict performance counter width.
REQ-004 SHALL use one clock, clk, and one reset, reset; reset is asynchronous and active-high.
REQ-005 SHALL have ports as follows (name, direction, width, meaning), clock and reset first:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous active-high reset
- in_valid  in  1  branch request present
- in_ready  out  1  unit can accept a request
- funct3  in  3  branch type
- rs1_data  in  XLEN  first operand
- rs2_data  in  XLEN  second operand
- pc  in  XLEN  branch instruction address
- imm  in  XLEN  sign-extended branch offset
- pred_taken  in  1  direction predicted at fetch
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_taken  out  1  resolved direction
- out_target  out  XLEN  next PC
- out_mispredict  out  1  resolved direction differs from prediction
- out_illegal  out  1  unsupported funct3
- lookup_pc  in  XLEN  fetch-side prediction address
- lookup_taken  out  1  predicted direction for lookup_pc
- mispredict_count  out  CNT_W  saturating mispredict total

Function
REQ-006 SHALL accept a request on any rising clk edge where in_valid and in_ready are both 1.
REQ-007 SHALL drive in_ready = !out_valid || out_ready (combinational); back-to-back acceptance every cycle is required when out_ready is held at 1.
REQ-008 SHALL register the result of an accepted request and assert out_valid on the following cycle (latency 1).
REQ-009 SHALL hold out_valid and all out_* fields stable while out_valid=1 and out_ready=0.
REQ-010 SHALL clear out_valid after an edge where out_valid=1, out_ready=1 and no new request is accepted.
REQ-011 SHALL resolve funct3 as follows:
- 000: taken if rs1 == rs2
- 001: taken if rs1 != rs2
- 100: taken if rs1 < rs2, signed
- 101: taken if rs1 >= rs2, signed
- 110: taken if rs1 < rs2, unsigned
- 111: taken if rs1 >= rs2, unsigned
REQ-012 SHALL treat funct3 010 and 011 as illegal: out_illegal=1, out_taken=0, out_mispredict=0, out_target=pc+4, no history update and no counter increment.
REQ-013 SHALL compute out_target = pc+imm when taken and pc+4 otherwise, both modulo 2^XLEN; wrap-around is silent.
REQ-014 SHALL set out_mispredict = out_taken XOR pred_taken for legal requests.
REQ-015 SHALL hold BHT_DEPTH 2-bit saturating counters, indexed by pc[log2(BHT_DEPTH)+1:2].
REQ-016 SHALL update the indexed counter on the acceptance edge of each legal request: +1 when taken, saturating at 3; -1 when not taken, saturating at 0.
REQ-017 SHALL drive lookup_taken as bit 1 of the counter indexed by lookup_pc, combinationally; when a lookup hits the entry being updated in the same cycle, it returns the pre-update value.
REQ-018 SHALL increment mispredict_count on the acceptance edge of each legal mispredicted request and saturate at all-ones.

Reset
REQ-019 SHALL, while reset=1 and independent of clk, force:
- out_valid=0, out_taken=0, out_mispredict=0, out_illegal=0
- out_target=0, mispredict_count=0
- every history counter to 01 (weakly not-taken)
REQ-020 SHALL discard any pending unconsumed result when reset asserts mid-operation.
REQ-021 SHALL hold in_ready=1 while reset=1 and after its release; out_valid stays 0 while reset=1, and no request is accepted until the first rising edge with reset=0.

Verification
REQ-022 SHALL pass this scenario: funct3=100, rs1=-1 (all ones), rs2=1, pc=0x1000, imm=0x20, pred_taken=0 -> next cycle out_valid=1, out_taken=1, out_target=0x1020, out_mispredict=1, mispredict_count=1.
REQ-023 SHALL pass this scenario: funct3=110 with the same operands -> out_taken=0, out_target=0x1004, out_mispredict=0.
REQ-024 SHALL pass this scenario: funct3=011 -> out_illegal=1, out_target=pc+4, counter unchanged, mispredict_count unchanged.
REQ-025 SHALL pass this scenario: three taken requests at pc=0x40, then lookup_pc=0x40 -> lookup_taken=1; then four not-taken requests -> lookup_taken=0, counter at 0.
REQ-026 SHALL pass this scenario: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and out_* held; out_ready=1 -> next request accepted the same edge the result is consumed.
REQ-027 SHALL pass this scenario: pc=all-ones minus 3, not taken -> out_target=0; reset pulse mid-stall -> out_valid=0 immediately and all counters read weakly not-taken.
